// File: rtl/mac_operand_feeder.sv
// ---------------------------------------------------------------------------
// mac_operand_feeder
//
// Sequencer that walks one mac_pe through a complete dot product. A start
// request clears the PE accumulator, then len operand pairs are read from two
// single-port memories (A and B, one-cycle read latency) and handed to the PE
// with matched valids. When the last pair has reached the PE, the
// accumulator is captured into result_o and done_o pulses for one cycle.
//
// Ports
//   clk_i, rst_ni        : clock, asynchronous active-low reset
//   start_i              : launch request, only honoured while idle
//   len_i                : vector length 0..2^ADDR_WIDTH, latched at start
//   a_base_i, b_base_i   : vector base addresses, latched at start
//   busy_o               : a job is in progress
//   done_o               : one-cycle completion pulse
//   result_o             : last captured accumulator value
//   mem_req_o            : read request to both memories
//   a_addr_o, b_addr_o   : read addresses (base + k, wrapping)
//   a_rdata_i, b_rdata_i : read data, valid the cycle after the request
//   pe_a_o, pe_b_o       : operands to the PE (zero when not valid)
//   pe_a_valid_o,
//   pe_b_valid_o         : operand valids, always driven identically
//   pe_acc_clr_o         : accumulator clear to the PE
//   pe_acc_i             : PE accumulator value
//   dbg_state_o          : current FSM state, for observation only
//
// Handshake: there is no back-pressure. A request issued in one cycle
// always returns data in the next cycle, and a valid presented to the PE is
// always consumed in the cycle it is presented.
// ---------------------------------------------------------------------------
module mac_operand_feeder #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic                      start_i,
    input  logic [ADDR_WIDTH:0]       len_i,
    input  logic [ADDR_WIDTH-1:0]     a_base_i,
    input  logic [ADDR_WIDTH-1:0]     b_base_i,
    output logic                      busy_o,
    output logic                      done_o,
    output logic [2*DATA_WIDTH-1:0]   result_o,
    output logic                      mem_req_o,
    output logic [ADDR_WIDTH-1:0]     a_addr_o,
    output logic [ADDR_WIDTH-1:0]     b_addr_o,
    input  logic [DATA_WIDTH-1:0]     a_rdata_i,
    input  logic [DATA_WIDTH-1:0]     b_rdata_i,
    output logic [DATA_WIDTH-1:0]     pe_a_o,
    output logic [DATA_WIDTH-1:0]     pe_b_o,
    output logic                      pe_a_valid_o,
    output logic                      pe_b_valid_o,
    output logic                      pe_acc_clr_o,
    input  logic [2*DATA_WIDTH-1:0]   pe_acc_i,
    output logic [2:0]                dbg_state_o
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_CLEAR   = 3'd1,
        S_FETCH   = 3'd2,
        S_DRAIN   = 3'd3,
        S_CAPTURE = 3'd4
    } state_t;

    localparam logic [ADDR_WIDTH-1:0] K_ONE   = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [ADDR_WIDTH:0]   LEN_ONE = {{ADDR_WIDTH{1'b0}}, 1'b1};

    state_t                    r_state;
    logic [ADDR_WIDTH:0]       r_len;
    logic [ADDR_WIDTH-1:0]     r_a_base;
    logic [ADDR_WIDTH-1:0]     r_b_base;
    logic [ADDR_WIDTH-1:0]     r_k;
    logic                      r_rd_vld;
    logic                      r_done;
    logic [2*DATA_WIDTH-1:0]   r_result;

    logic                      w_mem_req;
    logic [ADDR_WIDTH:0]       w_last_idx;
    logic                      w_last;

    // CLEAR issues index 0 only for a non-empty vector; FETCH always issues.
    assign w_mem_req  = ((r_state == S_CLEAR) && (r_len != '0)) ||
                        (r_state == S_FETCH);
    // k is compared one bit wider so len = 2^ADDR_WIDTH still terminates.
    assign w_last_idx = r_len - LEN_ONE;
    assign w_last     = ({1'b0, r_k} == w_last_idx);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state  <= S_IDLE;
            r_len    <= '0;
            r_a_base <= '0;
            r_b_base <= '0;
            r_k      <= '0;
            r_rd_vld <= 1'b0;
            r_done   <= 1'b0;
            r_result <= '0;
        end else begin
            // Read data arrives exactly one cycle after each request.
            r_rd_vld <= w_mem_req;
            r_done   <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start_i) begin
                        r_len    <= len_i;
                        r_a_base <= a_base_i;
                        r_b_base <= b_base_i;
                        r_k      <= '0;
                        r_state  <= S_CLEAR;
                    end
                end
                S_CLEAR: begin
                    if (r_len == '0) begin
                        r_state <= S_CAPTURE;
                    end else begin
                        r_k     <= r_k + K_ONE;
                        r_state <= w_last ? S_DRAIN : S_FETCH;
                    end
                end
                S_FETCH: begin
                    r_k <= r_k + K_ONE;
                    if (w_last) begin
                        r_state <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    // Last operand pair is at the PE this cycle.
                    r_state <= S_CAPTURE;
                end
                S_CAPTURE: begin
                    r_result <= pe_acc_i;
                    r_done   <= 1'b1;
                    r_state  <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign busy_o       = (r_state != S_IDLE);
    assign done_o       = r_done;
    assign result_o     = r_result;
    assign mem_req_o    = w_mem_req;
    assign a_addr_o     = r_a_base + r_k;
    assign b_addr_o     = r_b_base + r_k;
    assign pe_a_valid_o = r_rd_vld;
    assign pe_b_valid_o = r_rd_vld;
    assign pe_a_o       = r_rd_vld ? a_rdata_i : '0;
    assign pe_b_o       = r_rd_vld ? b_rdata_i : '0;
    assign pe_acc_clr_o = (r_state == S_CLEAR);
    assign dbg_state_o  = r_state;

endmodule

// File: tb/tb_mac_operand_feeder.sv
// ---------------------------------------------------------------------------
// tb_mac_operand_feeder
//
// Bench for mac_operand_feeder with DATA_WIDTH=16, ADDR_WIDTH=8. Provides
// behavioural A/B memories (one-cycle read latency) and a behavioural MAC PE
// (clear, then accumulate a*b on valid, 32-bit wrap). Inputs change and
// outputs are sampled on the falling clock edge.
// ---------------------------------------------------------------------------
module tb_mac_operand_feeder;

    localparam int DW = 16;
    localparam int AW = 8;

    logic            clk_i = 1'b0;
    logic            rst_ni;
    logic            start_i;
    logic [AW:0]     len_i;
    logic [AW-1:0]   a_base_i;
    logic [AW-1:0]   b_base_i;
    logic            busy_o;
    logic            done_o;
    logic [2*DW-1:0] result_o;
    logic            mem_req_o;
    logic [AW-1:0]   a_addr_o;
    logic [AW-1:0]   b_addr_o;
    logic [DW-1:0]   a_rdata_i;
    logic [DW-1:0]   b_rdata_i;
    logic [DW-1:0]   pe_a_o;
    logic [DW-1:0]   pe_b_o;
    logic            pe_a_valid_o;
    logic            pe_b_valid_o;
    logic            pe_acc_clr_o;
    logic [2*DW-1:0] pe_acc_i;
    logic [2:0]      dbg_state_o;

    mac_operand_feeder #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .start_i      (start_i),
        .len_i        (len_i),
        .a_base_i     (a_base_i),
        .b_base_i     (b_base_i),
        .busy_o       (busy_o),
        .done_o       (done_o),
        .result_o     (result_o),
        .mem_req_o    (mem_req_o),
        .a_addr_o     (a_addr_o),
        .b_addr_o     (b_addr_o),
        .a_rdata_i    (a_rdata_i),
        .b_rdata_i    (b_rdata_i),
        .pe_a_o       (pe_a_o),
        .pe_b_o       (pe_b_o),
        .pe_a_valid_o (pe_a_valid_o),
        .pe_b_valid_o (pe_b_valid_o),
        .pe_acc_clr_o (pe_acc_clr_o),
        .pe_acc_i     (pe_acc_i),
        .dbg_state_o  (dbg_state_o)
    );

    // ---------------- clock ----------------
    always #5 clk_i = ~clk_i;

    // ---------------- environment models ----------------
    logic [DW-1:0] mem_a [256];
    logic [DW-1:0] mem_b [256];

    always @(posedge clk_i) begin
        if (mem_req_o) begin
            a_rdata_i <= mem_a[a_addr_o];
            b_rdata_i <= mem_b[b_addr_o];
        end
    end

    always @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pe_acc_i <= '0;
        end else if (pe_acc_clr_o) begin
            pe_acc_i <= '0;
        end else if (pe_a_valid_o) begin
            pe_acc_i <= pe_acc_i + pe_a_o * pe_b_o;
        end
    end

    // ---------------- bookkeeping ----------------
    int n_checks = 0;
    int n_fail   = 0;

    int              j_done_n;
    int              j_clr_n;
    int              j_nclr;
    int              j_nreq;
    int              j_nvld;
    logic [2*DW-1:0] j_res;
    logic            j_busy_at_done;
    logic [AW-1:0]   got_a_q [$];
    logic [AW-1:0]   got_b_q [$];
    logic [AW-1:0]   exp_a_q [$];
    logic [AW-1:0]   exp_b_q [$];

    // ---------------- driver tasks ----------------
    // Called at a falling edge: presents a start request for the next edge.
    task automatic start_job(input int len, input logic [AW-1:0] ab, input logic [AW-1:0] bb);
        len_i    = len[AW:0];
        a_base_i = ab;
        b_base_i = bb;
        start_i  = 1'b1;
    endtask

    // Follows a job cycle by cycle (n=1 is the cycle after the start edge)
    // until done_o, recording what the DUT did. start_i is dropped after the
    // first edge unless hold is set, in which case it stays high until done.
    task automatic wait_done(input bit hold);
        bit seen;
        seen     = 1'b0;
        j_done_n = -1;
        j_clr_n  = -1;
        j_nclr   = 0;
        j_nreq   = 0;
        j_nvld   = 0;
        got_a_q.delete();
        got_b_q.delete();
        for (int n = 1; n <= 300 && !seen; n++) begin
            @(posedge clk_i);
            @(negedge clk_i);
            if (!hold) start_i = 1'b0;
            if (mem_req_o) begin
                j_nreq++;
                got_a_q.push_back(a_addr_o);
                got_b_q.push_back(b_addr_o);
            end
            if (pe_a_valid_o && pe_b_valid_o) j_nvld++;
            if (pe_acc_clr_o) begin
                j_nclr++;
                j_clr_n = n;
            end
            if (done_o) begin
                seen           = 1'b1;
                j_done_n       = n;
                j_res          = result_o;
                j_busy_at_done = busy_o;
                start_i        = 1'b0;
            end
        end
        n_checks++;
        if (!seen) begin
            n_fail++;
            $display("FAIL timeout: done_o not seen within 300 cycles (got none, required one)");
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst_ni  = 1'b0;
        start_i = 1'b0;
        len_i   = '0;
        a_base_i = '0;
        b_base_i = '0;
        repeat (3) @(negedge clk_i);
        n_checks++;
        if ({busy_o, done_o, mem_req_o, pe_acc_clr_o, pe_a_valid_o, pe_b_valid_o} !== 6'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl: got %b required 000000", {busy_o, done_o, mem_req_o, pe_acc_clr_o, pe_a_valid_o, pe_b_valid_o});
        end
        n_checks++;
        if (result_o !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_result: got %h required 00000000", result_o);
        end
        n_checks++;
        if ({pe_a_o, pe_b_o, a_addr_o, b_addr_o} !== 48'h0) begin
            n_fail++;
            $display("FAIL reset_data: got %h required 0", {pe_a_o, pe_b_o, a_addr_o, b_addr_o});
        end
        n_checks++;
        if (dbg_state_o !== 3'd0) begin
            n_fail++;
            $display("FAIL reset_state: got %0d required 0", dbg_state_o);
        end
        rst_ni = 1'b1;
        @(negedge clk_i);
    endtask

    task automatic test_basic();
        start_job(4, 8'h00, 8'h00);
        wait_done(1'b0);
        n_checks++;
        if (j_res !== 32'd70) begin
            n_fail++;
            $display("FAIL basic_result: got %0d required 70", j_res);
        end
        n_checks++;
        if (j_done_n !== 7) begin
            n_fail++;
            $display("FAIL basic_done_time: got T+%0d required T+7", j_done_n);
        end
        n_checks++;
        if (j_nreq !== 4) begin
            n_fail++;
            $display("FAIL basic_req_count: got %0d required 4", j_nreq);
        end
        n_checks++;
        if (j_clr_n !== 1 || j_nclr !== 1) begin
            n_fail++;
            $display("FAIL basic_clear: got at T+%0d x%0d required at T+1 x1", j_clr_n, j_nclr);
        end
        n_checks++;
        if (j_nvld !== 4) begin
            n_fail++;
            $display("FAIL basic_valid_count: got %0d required 4", j_nvld);
        end
        n_checks++;
        if (j_busy_at_done !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_busy_at_done: got %b required 0", j_busy_at_done);
        end
        exp_a_q = '{8'h00, 8'h01, 8'h02, 8'h03};
        n_checks++;
        if (got_a_q != exp_a_q) begin
            n_fail++;
            $display("FAIL basic_a_addr: got %p required %p", got_a_q, exp_a_q);
        end
    endtask

    task automatic test_len_zero();
        start_job(0, 8'h00, 8'h00);
        wait_done(1'b0);
        n_checks++;
        if (j_res !== 32'd0) begin
            n_fail++;
            $display("FAIL len0_result: got %0d required 0", j_res);
        end
        n_checks++;
        if (j_done_n !== 3) begin
            n_fail++;
            $display("FAIL len0_done_time: got T+%0d required T+3", j_done_n);
        end
        n_checks++;
        if (j_nreq !== 0) begin
            n_fail++;
            $display("FAIL len0_req_count: got %0d required 0", j_nreq);
        end
        n_checks++;
        if (j_clr_n !== 1) begin
            n_fail++;
            $display("FAIL len0_clear: got at T+%0d required at T+1", j_clr_n);
        end
    endtask

    task automatic test_back_to_back();
        start_job(2, 8'h20, 8'h30);
        wait_done(1'b0);
        n_checks++;
        if (j_res !== 32'd12) begin
            n_fail++;
            $display("FAIL b2b_job1_result: got %0d required 12", j_res);
        end
        // Still inside job 1's done cycle: request job 2 with no idle gap.
        start_job(1, 8'h40, 8'h50);
        wait_done(1'b0);
        n_checks++;
        if (j_res !== 32'd9) begin
            n_fail++;
            $display("FAIL b2b_job2_result: got %0d required 9", j_res);
        end
        n_checks++;
        if (j_done_n !== 4) begin
            n_fail++;
            $display("FAIL b2b_job2_done_time: got T+%0d required T+4", j_done_n);
        end
    endtask

    task automatic test_overflow();
        start_job(2, 8'h60, 8'h70);
        wait_done(1'b0);
        n_checks++;
        if (j_res !== 32'hFFFC0002) begin
            n_fail++;
            $display("FAIL overflow_result: got %h required fffc0002", j_res);
        end
    endtask

    task automatic test_addr_wrap();
        start_job(4, 8'hFE, 8'h10);
        wait_done(1'b0);
        exp_a_q = '{8'hFE, 8'hFF, 8'h00, 8'h01};
        exp_b_q = '{8'h10, 8'h11, 8'h12, 8'h13};
        n_checks++;
        if (got_a_q != exp_a_q) begin
            n_fail++;
            $display("FAIL wrap_a_addr: got %p required %p", got_a_q, exp_a_q);
        end
        n_checks++;
        if (got_b_q != exp_b_q) begin
            n_fail++;
            $display("FAIL wrap_b_addr: got %p required %p", got_b_q, exp_b_q);
        end
        n_checks++;
        if (j_res !== 32'd5) begin
            n_fail++;
            $display("FAIL wrap_result: got %0d required 5", j_res);
        end
    endtask

    task automatic test_start_held();
        start_job(4, 8'h00, 8'h00);
        wait_done(1'b1);
        n_checks++;
        if (j_res !== 32'd70 || j_done_n !== 7) begin
            n_fail++;
            $display("FAIL held_start_result: got %0d at T+%0d required 70 at T+7", j_res, j_done_n);
        end
        n_checks++;
        if (j_nclr !== 1 || j_nreq !== 4) begin
            n_fail++;
            $display("FAIL held_start_restart: got clears=%0d reqs=%0d required clears=1 reqs=4", j_nclr, j_nreq);
        end
    endtask

    task automatic test_reset_midflight();
        bit saw_done;
        saw_done = 1'b0;
        start_job(4, 8'h00, 8'h00);
        @(posedge clk_i);
        @(negedge clk_i);
        start_i = 1'b0;
        @(posedge clk_i);
        @(negedge clk_i);
        n_checks++;
        if (dbg_state_o !== 3'd2) begin
            n_fail++;
            $display("FAIL midrst_in_fetch: got state %0d required 2", dbg_state_o);
        end
        rst_ni = 1'b0;
        #1;
        n_checks++;
        if ({busy_o, done_o, mem_req_o, pe_acc_clr_o, pe_a_valid_o, pe_b_valid_o} !== 6'b0 ||
            {pe_a_o, pe_b_o} !== 32'h0 || result_o !== 32'h0) begin
            n_fail++;
            $display("FAIL midrst_outputs: got ctrl=%b ops=%h res=%h required all 0",
                     {busy_o, done_o, mem_req_o, pe_acc_clr_o, pe_a_valid_o, pe_b_valid_o},
                     {pe_a_o, pe_b_o}, result_o);
        end
        repeat (2) begin
            @(negedge clk_i);
            if (done_o) saw_done = 1'b1;
        end
        rst_ni = 1'b1;
        repeat (4) begin
            @(negedge clk_i);
            if (done_o) saw_done = 1'b1;
        end
        n_checks++;
        if (saw_done !== 1'b0) begin
            n_fail++;
            $display("FAIL midrst_no_done: got done pulse required none");
        end
        start_job(4, 8'h00, 8'h00);
        wait_done(1'b0);
        n_checks++;
        if (j_res !== 32'd70 || j_done_n !== 7) begin
            n_fail++;
            $display("FAIL midrst_rerun: got %0d at T+%0d required 70 at T+7", j_res, j_done_n);
        end
    endtask

    // ---------------- main sequence ----------------
    initial begin
        for (int i = 0; i < 256; i++) begin
            mem_a[i] = '0;
            mem_b[i] = '0;
        end
        // basic: A=[1,2,3,4], B=[5,6,7,8] at 0
        mem_a[0] = 16'd1; mem_a[1] = 16'd2; mem_a[2] = 16'd3; mem_a[3] = 16'd4;
        mem_b[0] = 16'd5; mem_b[1] = 16'd6; mem_b[2] = 16'd7; mem_b[3] = 16'd8;
        // back-to-back
        mem_a[8'h20] = 16'd2; mem_a[8'h21] = 16'd2;
        mem_b[8'h30] = 16'd3; mem_b[8'h31] = 16'd3;
        mem_a[8'h40] = 16'd3;
        mem_b[8'h50] = 16'd3;
        // overflow
        mem_a[8'h60] = 16'hFFFF; mem_a[8'h61] = 16'hFFFF;
        mem_b[8'h70] = 16'hFFFF; mem_b[8'h71] = 16'hFFFF;
        // wrap: A at FE,FF then 00,01 (values 1,1,1,2); B at 10..13 all 1
        mem_a[8'hFE] = 16'd1; mem_a[8'hFF] = 16'd1;
        mem_b[8'h10] = 16'd1; mem_b[8'h11] = 16'd1; mem_b[8'h12] = 16'd1; mem_b[8'h13] = 16'd1;

        test_reset();
        test_basic();
        test_len_zero();
        test_back_to_back();
        test_overflow();
        test_addr_wrap();
        test_start_held();
        test_reset_midflight();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mac_operand_feeder.md
# mac_operand_feeder

Sequencer that drives one `mac_pe` through a complete dot product. On `start_i` it clears the PE accumulator and streams `len_i` operand pairs from two single-port read memories (A and B) into the PE with matched valids. It then captures the accumulated result and reports completion. It sits between the control/CSR logic and each MAC PE, acting as the initiator for the PE's operand/valid/clear interface.

## Interface
Parameters:
- `DATA_WIDTH`, default 16: operand width; must match the attached PE.
- `ADDR_WIDTH`, default 8: memory address width; the vector length limit is 2^ADDR_WIDTH.

Ports:
- `clk_i`, in, 1: clock. All state updates on the rising edge.
- `rst_ni`, in, 1: reset, asynchronous, active-low.
- `start_i`, in, 1: launch request. Sampled only in IDLE.
- `len_i`, in, ADDR_WIDTH+1: vector length, 0 to 2^ADDR_WIDTH. Latched at start.
- `a_base_i`, in, ADDR_WIDTH: A vector base address. Latched at start.
- `b_base_i`, in, ADDR_WIDTH: B vector base address. Latched at start.
- `busy_o`, out, 1: high while a job is in progress.
- `done_o`, out, 1: one-cycle completion pulse.
- `result_o`, out, 2*DATA_WIDTH: last captured result. Held until the next capture.
- `mem_req_o`, out, 1: read request to both memories.
- `a_addr_o`, out, ADDR_WIDTH: A read address.
- `b_addr_o`, out, ADDR_WIDTH: B read address.
- `a_rdata_i`, in, DATA_WIDTH: A read data. Valid the cycle after the request.
- `b_rdata_i`, in, DATA_WIDTH: B read data. Valid the cycle after the request.
- `pe_a_o`, out, DATA_WIDTH: operand to the PE.
- `pe_b_o`, out, DATA_WIDTH: operand to the PE.
- `pe_a_valid_o`, out, 1: operand valid to the PE.
- `pe_b_valid_o`, out, 1: operand valid to the PE. Always equal to `pe_a_valid_o`.
- `pe_acc_clr_o`, out, 1: accumulator clear to the PE.
- `pe_acc_i`, in, 2*DATA_WIDTH: PE accumulator value.

## Operation
- FSM states: IDLE, CLEAR, FETCH, DRAIN, CAPTURE.
- IDLE:
  - `start_i`=1 latches `len_i`, `a_base_i`, `b_base_i`, clears the index counter k, and moves to CLEAR.
  - `start_i` in any other state is ignored.
- CLEAR:
  - `pe_acc_clr_o`=1.
  - If len≠0: `mem_req_o`=1 with addresses base+0, k←1. Next state is FETCH if len>1, else DRAIN.
  - If len=0: no request; next state is CAPTURE.
- FETCH:
  - `mem_req_o`=1, `a_addr_o`=a_base+k, `b_addr_o`=b_base+k, k←k+1.
  - Moves to DRAIN after issuing index len-1.
- DRAIN: no request. This is the cycle in which the last read data is presented to the PE. Next state is CAPTURE.
- Data path:
  - A registered flag `rd_vld` is set in every cycle following a `mem_req_o`=1 cycle.
  - `pe_a_valid_o` = `pe_b_valid_o` = `rd_vld`.
  - `pe_a_o` = `rd_vld` ? `a_rdata_i` : 0. `pe_b_o` likewise.
  - The PE accumulates on either valid, so both valids are always driven identically.
- CAPTURE: `result_o`←`pe_acc_i` and `done_o`←1, both registered. Returns to IDLE.
- `busy_o` = (state≠IDLE).
- Address arithmetic:
  - base+k is computed modulo 2^ADDR_WIDTH, so addresses wrap with no error.
  - k counts to at most 2^ADDR_WIDTH-1.
- Outputs when idle:
  - `mem_req_o`, the valids and the PE operands are 0.
  - Addresses hold their last value. Verification must not check them while `mem_req_o`=0.
- Reset, asserted at any time:
  - State←IDLE; k, `rd_vld`, `done_o`, `result_o` ← 0.
  - All outputs are therefore 0 at reset, including `busy_o`, `mem_req_o`, `pe_acc_clr_o` and both valids.
  - An in-flight job is discarded without a `done_o` pulse.

## Timing
- Start sampled in cycle T. Events in order:
  - T+1: CLEAR. Clear pulse and request for index 0.
  - T+1+k: request for index k.
  - T+2+k: PE valid with element k.
  - T+len+1: DRAIN. Valid for element len-1.
  - T+len+2: CAPTURE.
  - T+len+3: `done_o`=1, `result_o` valid, state IDLE.
- Latency from start to done is len+3 cycles. len=0 gives done at T+3 with result 0.
- The clear (edge ending T+1) always precedes the first valid (T+2), so no stale accumulation occurs.
- A `start_i` in the `done_o` cycle is accepted: back-to-back jobs are allowed with zero idle gap.
- Throughput is one operand pair per cycle; there are no stalls. The memories must accept a request every cycle.
- Result width is 2*DATA_WIDTH. Overflow wraps modulo 2^(2*DATA_WIDTH), inherited from the PE; no saturation.

## Test plan
- len=4, A=[1,2,3,4], B=[5,6,7,8], bases 0 → `result_o`=70, `done_o` at T+7, exactly 4 requests, clear at T+1.
- len=0 → no `mem_req_o`, `result_o`=0, `done_o` at T+3, clear still pulses at T+1.
- Back-to-back: job 1 (len=2, A=[2,2], B=[3,3]) gives 12. Start in job 1's done cycle with len=1, A=[3], B=[3] → 9, proving the clear took effect.
- DATA_WIDTH=16, len=2, all operands 0xFFFF → `result_o`=0xFFFC0002 (wrapped).
- ADDR_WIDTH=8, a_base=0xFE, b_base=0x10, len=4 → A addresses FE,FF,00,01; B addresses 10..13.
- `start_i` held high during FETCH is ignored. `rst_ni` low mid-FETCH → all outputs 0 immediately, no `done_o`; a new start after release completes correctly.
